// File: rtl/reg_74ls194.sv
// reg_74ls194: 4-bit bidirectional universal shift register (74LS194 style).
// Modes are selected by {s1_i, s0_i}: hold, shift toward Q3, shift toward Q0,
// and parallel load. Clear is synchronous and active-high. The cr_n_i pin name
// is kept for pin compatibility even though it is active-high.
// Bit n of the state register drives output Qn. Q0 is the left end and Q3 the right end.
module reg_74ls194 (
    input  logic gclk_i,   // clock (CP), rising edge
    input  logic cr_n_i,   // synchronous clear, active-high despite the name
    input  logic s0_i,     // mode select, low bit
    input  logic s1_i,     // mode select, high bit
    input  logic dsr_i,    // serial in at Q0 during shift right
    input  logic dsl_i,    // serial in at Q3 during shift left
    input  logic d0_i,
    input  logic d1_i,
    input  logic d2_i,
    input  logic d3_i,
    output logic q0_o,
    output logic q1_o,
    output logic q2_o,
    output logic q3_o
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [3:0] q_q;
    logic [3:0] q_d;
    mode_e      mode;

    assign mode = mode_e'({s1_i, s0_i});

    // Next-state selection. An unknown mode select falls into the default branch,
    // so the register holds in simulation.
    always_comb begin
        q_d = q_q;
        case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = {q_q[2:0], dsr_i};       // Q0 <- DSr, Qn <- Qn-1
            MODE_SHL:  q_d = {dsl_i, q_q[3:1]};       // Q3 <- DSl, Qn <- Qn+1
            MODE_LOAD: q_d = {d3_i, d2_i, d1_i, d0_i};
            default:   q_d = q_q;
        endcase
    end

    // State register. Clear takes priority over every mode.
    always_ff @(posedge gclk_i) begin
        if (cr_n_i) q_q <= 4'b0000;
        else        q_q <= q_d;
    end

    assign q0_o = q_q[0];
    assign q1_o = q_q[1];
    assign q2_o = q_q[2];
    assign q3_o = q_q[3];

endmodule

// File: tb/tb_reg_74ls194.sv
// tb_reg_74ls194: directed checks followed by random stimulus compared against an
// arithmetic reference model of the register value.
module tb_reg_74ls194;

    logic gclk = 1'b0;
    logic cr, s0, s1, dsr, dsl, d0, d1, d2, d3;
    logic q0, q1, q2, q3;

    int n_chk = 0;
    int n_err = 0;
    int model = 0;   // Q3..Q0 held as the integer value sum(Qn * 2^n)

    always #5 gclk = ~gclk;

    reg_74ls194 dut (
        .gclk_i(gclk), .cr_n_i(cr), .s0_i(s0), .s1_i(s1),
        .dsr_i(dsr), .dsl_i(dsl),
        .d0_i(d0), .d1_i(d1), .d2_i(d2), .d3_i(d3),
        .q0_o(q0), .q1_o(q1), .q2_o(q2), .q3_o(q3)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] q_hi2lo();   // {Q3,Q2,Q1,Q0}
        return {q3, q2, q1, q0};
    endfunction

    function automatic logic [3:0] q_lo2hi();   // {Q0,Q1,Q2,Q3}
        return {q0, q1, q2, q3};
    endfunction

    // Advance the reference model using the inputs present at the edge.
    task automatic model_step();
        if (cr) model = 0;
        else begin
            case ({s1, s0})
                2'b01:   model = (model * 2 + int'(dsr)) % 16;
                2'b10:   model = model / 2 + int'(dsl) * 8;
                2'b11:   model = int'(d0) + 2 * int'(d1) + 4 * int'(d2) + 8 * int'(d3);
                default: model = model;
            endcase
        end
    endtask

    // One rising edge. Sampling happens 1 time unit after the edge.
    task automatic step();
        @(posedge gclk);
        model_step();
        #1;
    endtask

    task automatic set_d(input logic [3:0] v);   // v = D3..D0
        {d3, d2, d1, d0} = v;
    endtask

    initial begin
        logic [3:0] sl_seq, sr_seq, exp_lr;
        cr = 1'b0; s0 = 1'b0; s1 = 1'b0; dsr = 1'b0; dsl = 1'b0; set_d(4'h0);
        #2;

        // Reset wins over load with all ones.
        cr = 1'b1; {s1, s0} = 2'b11; set_d(4'b1111); dsr = 1'b1; dsl = 1'b1;
        step();
        chk("reset", q_hi2lo(), 4'b0000);
        cr = 1'b0; {s1, s0} = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_after_reset", q_hi2lo(), 4'b0000);
        end

        // Shift left, DSl = 1,0,0,1.
        sl_seq = 4'b1001;
        {s1, s0} = 2'b10; dsr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dsl = sl_seq[3-i];
            dsr = ~dsr;
            step();
            case (i)
                0: exp_lr = 4'b0001;
                1: exp_lr = 4'b0010;
                2: exp_lr = 4'b0100;
                default: exp_lr = 4'b1001;
            endcase
            chk("shift_left", q_lo2hi(), exp_lr);
        end
        {s1, s0} = 2'b00;
        for (int i = 0; i < 3; i++) begin
            dsl = ~dsl;
            step();
            chk("hold_after_shl", q_lo2hi(), 4'b1001);
        end

        // Shift right from zero, DSr = 0,1,1,0.
        cr = 1'b1; step(); cr = 1'b0;
        chk("reset_before_shr", q_hi2lo(), 4'b0000);
        sr_seq = 4'b0110;
        {s1, s0} = 2'b01;
        for (int i = 0; i < 4; i++) begin
            dsr = sr_seq[3-i];
            dsl = ~dsl;
            step();
            case (i)
                0: exp_lr = 4'b0000;
                1: exp_lr = 4'b1000;
                2: exp_lr = 4'b1100;
                default: exp_lr = 4'b0110;
            endcase
            chk("shift_right", q_lo2hi(), exp_lr);
        end

        // Parallel load ignores serial inputs.
        {s1, s0} = 2'b11; set_d(4'b1100); dsr = 1'b1; dsl = 1'b0;
        step();
        chk("load", q_hi2lo(), 4'b1100);
        dsr = 1'b0; dsl = 1'b1;
        step();
        chk("load_serial_ignored", q_hi2lo(), 4'b1100);
        {s1, s0} = 2'b00; set_d(4'b0011);
        step();
        chk("hold_after_load", q_hi2lo(), 4'b1100);

        // Clear beats shift, then shifting resumes.
        {s1, s0} = 2'b11; set_d(4'b1010);
        step();
        chk("load_1010", q_hi2lo(), 4'b1010);
        {s1, s0} = 2'b01; cr = 1'b1; dsr = 1'b1;
        step();
        chk("clear_mid_shift", q_hi2lo(), 4'b0000);
        cr = 1'b0;
        step();
        chk("resume_shr", q_hi2lo(), 4'b0001);

        // Random stimulus against the model. The model is brought in line with the DUT state here.
        model = int'(q_hi2lo());
        for (int i = 0; i < 400; i++) begin
            cr  = ($urandom_range(0, 15) == 0);
            {s1, s0} = 2'($urandom_range(0, 3));
            dsr = 1'($urandom);
            dsl = 1'($urandom);
            set_d(4'($urandom));
            step();
            chk("random", q_hi2lo(), 4'(model));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
